// File: rtl/freq_channel_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_channel_meter
// Brief    : Reciprocal frequency meter for one channel. It counts clk_i
//            cycles across N rising edges of an asynchronous Fin_i and then
//            offers the result through a start/ready/ack handshake.
// Options  : FREQ_CH_IRQ_EN adds irq_o, a one-cycle pulse on result arrival.
// Revision : 1.0 - initial release
// ============================================================================
module freq_channel_meter #(
    parameter int MASTER_W = 30,
    parameter int PERIOD_W = 24
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                Fin_i,
    input  logic [PERIOD_W-1:0] reload_i,
    input  logic                start_i,
    input  logic                ack_i,
    output logic                busy_o,
    output logic                ready_o,
    output logic                overflow_o,
    output logic [MASTER_W-1:0] master_count_o,
    output logic [PERIOD_W-1:0] periods_o
`ifdef FREQ_CH_IRQ_EN
    ,
    output logic                irq_o
`endif
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_meas = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [MASTER_W-1:0] c_ref_max = {MASTER_W{1'b1}};
    localparam logic [MASTER_W-1:0] c_ref_one = {{(MASTER_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] c_per_one = {{(PERIOD_W-1){1'b0}}, 1'b1};

    // Synchronizer stages
    logic s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;

    // Control and counters
    logic [1:0]          state_q, state_d;
    logic [PERIOD_W-1:0] n_q, n_d;          // requested period count
    logic [MASTER_W-1:0] ref_q, ref_d;      // reference (clk_i) counter
    logic [PERIOD_W-1:0] per_q, per_d;      // periods seen in MEASURE

    // Result registers, only rewritten on DONE entry
    logic [MASTER_W-1:0] mc_q, mc_d;
    logic [PERIOD_W-1:0] po_q, po_d;
    logic                ov_q, ov_d;

    // Registered status
    logic busy_q, busy_d;
    logic ready_q, ready_d;

    logic                w_edge;
    logic [MASTER_W-1:0] w_ref_inc;
    logic                w_ref_sat;
    logic [PERIOD_W-1:0] w_per_inc;
    logic                w_per_hit;
    logic [PERIOD_W-1:0] w_n_load;

    assign w_edge    = s1_q & ~s2_q;
    assign w_ref_inc = ref_q + c_ref_one;
    assign w_ref_sat = (w_ref_inc == c_ref_max);
    assign w_per_inc = per_q + c_per_one;
    assign w_per_hit = (w_per_inc == n_q);
    // A request for zero periods behaves as a single-period measurement
    assign w_n_load  = (reload_i == '0) ? c_per_one : reload_i;

    // Synchronizer shift of the asynchronous input
    always_comb begin
        s0_d = Fin_i;
        s1_d = s0_q;
        s2_d = s1_q;
    end

    // State register plus all datapath flops, cleared by the active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= c_st_idle;
            n_q     <= '0;
            ref_q   <= '0;
            per_q   <= '0;
            mc_q    <= '0;
            po_q    <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            n_q     <= n_d;
            ref_q   <= ref_d;
            per_q   <= per_d;
            mc_q    <= mc_d;
            po_q    <= po_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Next state, counter updates and result capture on DONE entry
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        ref_d   = ref_q;
        per_d   = per_q;
        mc_d    = mc_q;
        po_d    = po_q;
        ov_d    = ov_q;
        case (state_q)
            c_st_idle: begin
                if (start_i) begin
                    n_d     = w_n_load;
                    ref_d   = '0;
                    state_d = c_st_arm;
                end
            end
            c_st_arm: begin
                if (w_edge) begin
                    // First edge defines time zero for the measurement
                    ref_d   = '0;
                    per_d   = '0;
                    state_d = c_st_meas;
                end else if (w_ref_sat) begin
                    ref_d   = w_ref_inc;
                    mc_d    = c_ref_max;
                    po_d    = '0;
                    ov_d    = 1'b1;
                    state_d = c_st_done;
                end else begin
                    ref_d = w_ref_inc;
                end
            end
            c_st_meas: begin
                ref_d = w_ref_inc;
                if (w_edge) begin
                    per_d = w_per_inc;
                end
                // A completing edge wins over a simultaneous saturation since
                // the count is then exact
                if (w_edge && w_per_hit) begin
                    mc_d    = w_ref_inc;
                    po_d    = w_per_inc;
                    ov_d    = 1'b0;
                    state_d = c_st_done;
                end else if (w_ref_sat) begin
                    mc_d    = c_ref_max;
                    po_d    = w_edge ? w_per_inc : per_q;
                    ov_d    = 1'b1;
                    state_d = c_st_done;
                end
            end
            default: begin
                // DONE: a start acts as an implicit acknowledge and re-arms
                if (start_i) begin
                    n_d     = w_n_load;
                    ref_d   = '0;
                    state_d = c_st_arm;
                end else if (ack_i) begin
                    state_d = c_st_idle;
                end
            end
        endcase
    end

    // Status flags follow the next state so they are registered alongside it
    always_comb begin
        busy_d  = (state_d == c_st_arm) || (state_d == c_st_meas);
        ready_d = (state_d == c_st_done);
    end

    assign busy_o         = busy_q;
    assign ready_o        = ready_q;
    assign overflow_o     = ov_q;
    assign master_count_o = mc_q;
    assign periods_o      = po_q;

`ifdef FREQ_CH_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt pulse coincides with the first cycle of ready_o
    always_comb begin
        irq_d = ready_d & ~ready_q;
    end

    // Interrupt pulse register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_channel_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_channel_meter
// Brief    : Directed bench for freq_channel_meter; dut_a uses the default
//            widths, dut_b uses an 8-bit reference counter for overflow cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_channel_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        ack = 1'b0;
    logic [23:0] reload = '0;
    logic        fin_en = 1'b0;
    logic [3:0]  fin_sel = 4'd1;
    logic [15:0] div = '0;
    logic        fin;

    logic        busy_a, ready_a, ov_a;
    logic [29:0] mc_a;
    logic [23:0] po_a;
    logic        busy_b, ready_b, ov_b;
    logic [7:0]  mc_b;
    logic [23:0] po_b;
`ifdef FREQ_CH_IRQ_EN
    logic        irq_a, irq_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 16'd1;
    assign fin = fin_en & div[fin_sel];

    freq_channel_meter dut_a (
        .clk_i(clk), .rst_i(rst), .Fin_i(fin), .reload_i(reload),
        .start_i(start_a), .ack_i(ack), .busy_o(busy_a), .ready_o(ready_a),
        .overflow_o(ov_a), .master_count_o(mc_a), .periods_o(po_a)
`ifdef FREQ_CH_IRQ_EN
        , .irq_o(irq_a)
`endif
    );

    freq_channel_meter #(.MASTER_W(8), .PERIOD_W(24)) dut_b (
        .clk_i(clk), .rst_i(rst), .Fin_i(fin), .reload_i(reload),
        .start_i(start_b), .ack_i(ack), .busy_o(busy_b), .ready_o(ready_b),
        .overflow_o(ov_b), .master_count_o(mc_b), .periods_o(po_b)
`ifdef FREQ_CH_IRQ_EN
        , .irq_o(irq_b)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic sel_b, input logic [23:0] n);
        reload = n;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_ready(input logic sel_b, input int budget, output int cycles);
        cycles = 0;
        while (!(sel_b ? ready_b : ready_a) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= budget) check_value("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_busy", busy_a, 0);
        check_value("rst_ready", ready_a, 0);
        check_value("rst_ovf", ov_a, 0);
        check_value("rst_master", mc_a, 0);
        check_value("rst_periods", po_a, 0);
`ifdef FREQ_CH_IRQ_EN
        check_value("rst_irq", irq_a, 0);
`endif
        rst = 1'b1;

        // clk/4, N=10 -> 40 cycles
        fin_sel = 4'd1; fin_en = 1'b1;
        repeat (4) @(negedge clk);
        pulse_start(1'b0, 24'd10);
        check_value("t1_busy", busy_a, 1);
        check_value("t1_ready_low", ready_a, 0);
        wait_ready(1'b0, 200, cyc);
`ifdef FREQ_CH_IRQ_EN
        check_value("t1_irq_rise", irq_a, 1);
`endif
        check_value("t1_master", mc_a, 40);
        check_value("t1_periods", po_a, 10);
        check_value("t1_ovf", ov_a, 0);
        check_value("t1_busy_done", busy_a, 0);
        @(negedge clk);
`ifdef FREQ_CH_IRQ_EN
        check_value("t1_irq_single", irq_a, 0);
`endif
        check_value("t1_ready_hold", ready_a, 1);
        pulse_ack();
        check_value("t1_ack_ready", ready_a, 0);
        check_value("t1_ack_keep", mc_a, 40);

        // clk/512, N=0 treated as 1
        fin_sel = 4'd8;
        repeat (4) @(negedge clk);
        pulse_start(1'b0, 24'd0);
        wait_ready(1'b0, 3000, cyc);
        check_value("t2_master", mc_a, 512);
        check_value("t2_periods", po_a, 1);
        check_value("t2_ovf", ov_a, 0);
        pulse_ack();

        // Fin idle, 8-bit counter saturates in ARM after 255 cycles
        fin_en = 1'b0;
        repeat (4) @(negedge clk);
        pulse_start(1'b1, 24'd0);
        wait_ready(1'b1, 400, cyc);
        check_value("t3_latency", cyc, 255);
        check_value("t3_ovf", ov_b, 1);
        check_value("t3_master", mc_b, 8'hFF);
        check_value("t3_periods", po_b, 0);
        pulse_ack();

        // clk/16, N=100, 8-bit counter saturates in MEASURE after 15 periods
        fin_sel = 4'd3; fin_en = 1'b1;
        repeat (4) @(negedge clk);
        pulse_start(1'b1, 24'd100);
        wait_ready(1'b1, 600, cyc);
        check_value("t4_ovf", ov_b, 1);
        check_value("t4_periods", po_b, 15);
        check_value("t4_master", mc_b, 8'hFF);
        pulse_ack();

        // Reset mid-measurement abandons it
        fin_sel = 4'd1;
        repeat (4) @(negedge clk);
        pulse_start(1'b0, 24'd1000);
        repeat (50) @(negedge clk);
        check_value("t5_busy_pre", busy_a, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_value("t5_busy", busy_a, 0);
        check_value("t5_ready", ready_a, 0);
        check_value("t5_master", mc_a, 0);
        check_value("t5_periods", po_a, 0);
        check_value("t5_ovf", ov_a, 0);
        repeat (100) @(negedge clk);
        check_value("t5_no_ready", ready_a, 0);
        check_value("t5_idle", busy_a, 0);

        // A start while busy is ignored: the first N=10 run completes
        pulse_start(1'b0, 24'd10);
        repeat (5) @(negedge clk);
        pulse_start(1'b0, 24'd2);
        wait_ready(1'b0, 200, cyc);
        check_value("t5_ign_master", mc_a, 40);
        check_value("t5_ign_periods", po_a, 10);

        // Start in DONE re-arms without an ack
        pulse_start(1'b0, 24'd10);
        check_value("t6_ready_fall", ready_a, 0);
        check_value("t6_busy_rise", busy_a, 1);
        wait_ready(1'b0, 200, cyc);
`ifdef FREQ_CH_IRQ_EN
        check_value("t6_irq_rise", irq_a, 1);
`endif
        check_value("t6_master", mc_a, 40);
        @(negedge clk);
`ifdef FREQ_CH_IRQ_EN
        check_value("t6_irq_single", irq_a, 0);
`endif
        check_value("t6_ready_hold", ready_a, 1);
        pulse_ack();
        check_value("t6_ack_ready", ready_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
